// File: rtl/demux4_16b_buf_if.sv
// Bus bundle for demux4_16b_buf: one producer-side stream in, four
// consumer-side streams out, plus flush and busy.
interface demux4_16b_buf_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       sel;
  logic             flush;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             c_valid;
  logic             c_ready;
  logic [WIDTH-1:0] c_data;
  logic             d_valid;
  logic             d_ready;
  logic [WIDTH-1:0] d_data;
  logic             busy;

  // Environment side: producer and the four consumers.
  modport master (
    output in_valid, in_data, sel, flush,
    output a_ready, b_ready, c_ready, d_ready,
    input  in_ready,
    input  a_valid, a_data, b_valid, b_data,
    input  c_valid, c_data, d_valid, d_data,
    input  busy
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, sel, flush,
    input  a_ready, b_ready, c_ready, d_ready,
    output in_ready,
    output a_valid, a_data, b_valid, b_data,
    output c_valid, c_data, d_valid, d_data,
    output busy
  );
endinterface

// File: rtl/demux4_16b_buf.sv
// demux4_16b_buf: steers one input stream to one of four destinations
// (sel 00->a, 01->b, 10->c, 11->d). Every destination owns a small FIFO so
// a stalled consumer only blocks words addressed to it. The head word of each
// FIFO is kept in its own register so x_data is registered and holds its last
// value while x_valid is low.
module demux4_16b_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  demux4_16b_buf_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]            w_ready;
  logic [3:0]            w_valid;
  logic [3:0][WIDTH-1:0] w_data;
  logic [3:0][CW-1:0]    w_count;
  logic                  w_sel_full;
  logic                  w_sel_drain;
  logic                  w_accept;

  assign w_ready = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};

  // A full FIFO may still accept when its head leaves in the same cycle.
  assign w_sel_full   = (w_count[bus.sel] == FULL_CNT);
  assign w_sel_drain  = w_valid[bus.sel] & w_ready[bus.sel];
  assign bus.in_ready = ~bus.flush & (~w_sel_full | w_sel_drain);
  assign w_accept     = bus.in_valid & bus.in_ready;

  assign bus.a_valid = w_valid[0];
  assign bus.a_data  = w_data[0];
  assign bus.b_valid = w_valid[1];
  assign bus.b_data  = w_data[1];
  assign bus.c_valid = w_valid[2];
  assign bus.c_data  = w_data[2];
  assign bus.d_valid = w_valid[3];
  assign bus.d_data  = w_data[3];
  assign bus.busy    = |w_valid;

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             w_wr;
    logic             w_rd;
    logic [PW-1:0]    w_rd_next;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_head_next;

    assign w_wr      = w_accept & (bus.sel == 2'(g));
    assign w_rd      = w_valid[g] & w_ready[g] & ~bus.flush;
    assign w_rd_next = w_rd ? (r_rd_ptr + PW'(1)) : r_rd_ptr;

    assign w_valid[g] = (r_count != {CW{1'b0}});
    assign w_data[g]  = r_head;
    assign w_count[g] = r_count;

    // Occupancy after this edge: flush clears, read+write cancel out.
    always_comb begin
      w_count_next = r_count;
      if (bus.flush) begin
        w_count_next = {CW{1'b0}};
      end else begin
        case ({w_wr, w_rd})
          2'b10:   w_count_next = r_count + CW'(1);
          2'b01:   w_count_next = r_count - CW'(1);
          default: w_count_next = r_count;
        endcase
      end
    end

    // Head word after this edge; the incoming word becomes head when it lands
    // exactly in the slot the read pointer will point at.
    always_comb begin
      w_head_next = r_head;
      if (bus.flush) begin
        w_head_next = r_head;
      end else if (w_count_next == {CW{1'b0}}) begin
        w_head_next = r_head;
      end else if (w_wr && (r_wr_ptr == w_rd_next)) begin
        w_head_next = bus.in_data;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end

    // FIFO storage, pointers, count and head register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= {WIDTH{1'b0}};
        end
        r_wr_ptr <= {PW{1'b0}};
        r_rd_ptr <= {PW{1'b0}};
        r_count  <= {CW{1'b0}};
        r_head   <= {WIDTH{1'b0}};
      end else if (bus.flush) begin
        r_wr_ptr <= {PW{1'b0}};
        r_rd_ptr <= {PW{1'b0}};
        r_count  <= {CW{1'b0}};
      end else begin
        if (w_wr) begin
          r_mem[r_wr_ptr] <= bus.in_data;
          r_wr_ptr        <= r_wr_ptr + PW'(1);
        end else begin
          r_wr_ptr <= r_wr_ptr;
        end
        r_rd_ptr <= w_rd_next;
        r_count  <= w_count_next;
        r_head   <= w_head_next;
      end
    end
  end

endmodule
